param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count, sticky overflow/underflow,
// and a choice of registered-read or first-word-fall-through output.
module param_sync_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A write into a full FIFO is legal when a read frees a slot on the same edge.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AF_LEVEL));
    assign almost_empty = (level <= LW'(AE_LEVEL));

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[w_ptr] <= data_in;
        end
    end

    // Explicit wrap so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= (w_ptr == PTR_LAST) ? '0 : w_ptr + 1'b1;
            end
            if (rd_acc) begin
                r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (wr_acc && !rd_acc) begin
            level <= level + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (r_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[r_ptr];
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out <= '0;
                end else if (rd_acc) begin
                    data_out <= mem[r_ptr];
                end
            end
        end
    endgenerate

endmodule
